// File: rtl/citometer_pkg.sv
// Shared sequencer types, record/counter widths and default parameters for the citometer pulse path.
package citometer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FLUSH,
    ARMED,
    EVENT,
    REPORT,
    HOLDOFF
  } state_t;

  localparam int EVT_WIDTH_W = 12;
  localparam int EVT_COUNT_W = 32;
  localparam int REJ_COUNT_W = 16;
  localparam int TIME_W      = 32;
  localparam int CNT_W       = 16;

  localparam int DWIDTH_DEF      = 14;
  localparam int SWIDTH_DEF      = 2 * DWIDTH_DEF;
  localparam int MAX_SAMPLES_DEF = 512;
  localparam int MIN_WIDTH_DEF   = 4;
  localparam int MAX_WIDTH_DEF   = 4095;
  localparam int DEAD_TIME_DEF   = 64;

endpackage

// File: rtl/event_capture.sv
// Peak/width capture of one pulse: load starts a record, upd extends it.
// Latency: record registers update on the clock after load/upd; full is combinational.
// Backpressure: none here; the record simply holds while neither load nor upd is asserted.
module event_capture
  import citometer_pkg::*;
#(
  parameter int SWIDTH    = SWIDTH_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   load,
  input  logic                   upd,
  input  logic [SWIDTH-1:0]      cusum,
  output logic [SWIDTH-1:0]      peak,
  output logic [EVT_WIDTH_W-1:0] width,
  output logic                   sat,
  output logic                   full
);

  // This update brings width to MAX_WIDTH, so the pulse is closed as saturated.
  assign full = upd && (width == EVT_WIDTH_W'(MAX_WIDTH - 1));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      peak  <= '0;
      width <= '0;
      sat   <= 1'b0;
    end else if (load) begin
      peak  <= cusum;
      width <= EVT_WIDTH_W'(1);
      sat   <= 1'b0;
    end else if (upd) begin
      width <= width + 1'b1;
      if (cusum > peak) peak <= cusum;
      if (full) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/event_sequencer.sv
// Pulse sequencer around a cumulative adder; optional EVT_TIME stamp under EVENT_TIMESTAMP_EN.
// Latency: ADDER_ENABLE follows SAMPLE_VALID combinationally; adder outputs are judged one cycle later.
// Backpressure: a finished record waits in REPORT with EVT_VALID high until EVT_READY; nothing is dropped.
module event_sequencer
  import citometer_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int SWIDTH      = 2 * DWIDTH,
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF,
  parameter int MIN_WIDTH   = MIN_WIDTH_DEF,
  parameter int MAX_WIDTH   = MAX_WIDTH_DEF,
  parameter int DEAD_TIME   = DEAD_TIME_DEF
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   SAMPLE_VALID,
  input  logic                   ADDER_TRIGGER,
  input  logic [SWIDTH-1:0]      ADDER_CUSUM,
  output logic                   ADDER_ENABLE,
  output logic                   ADDER_CLEAR,
  output logic                   EVT_VALID,
  input  logic                   EVT_READY,
  output logic [SWIDTH-1:0]      EVT_PEAK,
  output logic [EVT_WIDTH_W-1:0] EVT_WIDTH,
  output logic                   EVT_SAT,
  output logic [EVT_COUNT_W-1:0] EVT_COUNT,
  output logic [REJ_COUNT_W-1:0] REJ_COUNT,
  output logic                   BUSY
`ifdef EVENT_TIMESTAMP_EN
  ,
  output logic [TIME_W-1:0]      EVT_TIME
`endif
);

  state_t           state;
  logic             q_vld;
  logic [CNT_W-1:0] cnt;
  logic             stop_pend;
  logic             cap_load;
  logic             cap_upd;
  logic             cap_full;

  assign ADDER_ENABLE = SAMPLE_VALID && (state != IDLE) && (state != CLEAR);
  assign BUSY         = (state != IDLE);

  // The adder answers one cycle after it was enabled, so q_vld marks when its outputs are meaningful.
  assign cap_load = (state == ARMED) && q_vld && ADDER_TRIGGER && !STOP;
  assign cap_upd  = (state == EVENT) && q_vld && ADDER_TRIGGER && !STOP;

  event_capture #(
    .SWIDTH    (SWIDTH),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_capture (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .load    (cap_load),
    .upd     (cap_upd),
    .cusum   (ADDER_CUSUM),
    .peak    (EVT_PEAK),
    .width   (EVT_WIDTH),
    .sat     (EVT_SAT),
    .full    (cap_full)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      q_vld       <= 1'b0;
      cnt         <= '0;
      stop_pend   <= 1'b0;
      ADDER_CLEAR <= 1'b0;
      EVT_VALID   <= 1'b0;
      EVT_COUNT   <= '0;
      REJ_COUNT   <= '0;
    end else begin
      q_vld       <= ADDER_ENABLE;
      ADDER_CLEAR <= 1'b0;
      if (STOP && state != REPORT) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (START) begin
            state       <= CLEAR;
            ADDER_CLEAR <= 1'b1;
          end
          CLEAR: begin
            state <= FLUSH;
            cnt   <= '0;
          end
          FLUSH: if (q_vld) begin
            if (cnt == CNT_W'(MAX_SAMPLES - 1)) begin
              state <= ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ARMED: if (cap_load) state <= EVENT;
          EVENT: begin
            if (cap_full) begin
              state     <= REPORT;
              EVT_VALID <= 1'b1;
            end else if (q_vld && !ADDER_TRIGGER) begin
              if (EVT_WIDTH >= EVT_WIDTH_W'(MIN_WIDTH)) begin
                state     <= REPORT;
                EVT_VALID <= 1'b1;
              end else begin
                state <= HOLDOFF;
                cnt   <= '0;
                if (REJ_COUNT != {REJ_COUNT_W{1'b1}}) REJ_COUNT <= REJ_COUNT + 1'b1;
              end
            end
          end
          REPORT: begin
            // A STOP here waits for the record to be taken so it is never lost.
            if (STOP) stop_pend <= 1'b1;
            if (EVT_VALID && EVT_READY) begin
              EVT_VALID <= 1'b0;
              EVT_COUNT <= EVT_COUNT + 1'b1;
              stop_pend <= 1'b0;
              cnt       <= '0;
              state     <= (stop_pend || STOP) ? IDLE : HOLDOFF;
            end
          end
          HOLDOFF: if (q_vld) begin
            if (cnt != CNT_W'(DEAD_TIME - 1)) begin
              cnt <= cnt + 1'b1;
            end else if (!ADDER_TRIGGER) begin
              state <= ARMED;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef EVENT_TIMESTAMP_EN
  logic [TIME_W-1:0] qual_time;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      qual_time <= '0;
      EVT_TIME  <= '0;
    end else begin
      if (q_vld) qual_time <= qual_time + 1'b1;
      if (cap_load) EVT_TIME <= qual_time;
    end
  end
`endif

endmodule

// File: tb/tb_event_sequencer.sv
// Directed bench for event_sequencer: flush, normal event, reject/holdoff, backpressure+STOP, saturation, async reset.
module tb_event_sequencer;
  import citometer_pkg::*;

  logic        CLOCK;
  logic        RESET_N;
  logic        START;
  logic        STOP;
  logic        SAMPLE_VALID;
  logic        ADDER_TRIGGER;
  logic [27:0] ADDER_CUSUM;
  logic        ADDER_ENABLE;
  logic        ADDER_CLEAR;
  logic        EVT_VALID;
  logic        EVT_READY;
  logic [27:0] EVT_PEAK;
  logic [11:0] EVT_WIDTH;
  logic        EVT_SAT;
  logic [31:0] EVT_COUNT;
  logic [15:0] REJ_COUNT;
  logic        BUSY;
`ifdef EVENT_TIMESTAMP_EN
  logic [31:0] EVT_TIME;
`endif

  int n_vec = 0;
  int n_err = 0;

  event_sequencer dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .START         (START),
    .STOP          (STOP),
    .SAMPLE_VALID  (SAMPLE_VALID),
    .ADDER_TRIGGER (ADDER_TRIGGER),
    .ADDER_CUSUM   (ADDER_CUSUM),
    .ADDER_ENABLE  (ADDER_ENABLE),
    .ADDER_CLEAR   (ADDER_CLEAR),
    .EVT_VALID     (EVT_VALID),
    .EVT_READY     (EVT_READY),
    .EVT_PEAK      (EVT_PEAK),
    .EVT_WIDTH     (EVT_WIDTH),
    .EVT_SAT       (EVT_SAT),
    .EVT_COUNT     (EVT_COUNT),
    .REJ_COUNT     (REJ_COUNT),
    .BUSY          (BUSY)
`ifdef EVENT_TIMESTAMP_EN
    ,
    .EVT_TIME      (EVT_TIME)
`endif
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One ADC sample: strobe, then present the adder's answer on the following (qualified) cycle.
  task automatic sample(input logic trig, input logic [27:0] cs);
    SAMPLE_VALID  = 1'b1;
    ADDER_TRIGGER = 1'b0;
    tick();
    SAMPLE_VALID  = 1'b0;
    ADDER_TRIGGER = trig;
    ADDER_CUSUM   = cs;
    tick();
    ADDER_TRIGGER = 1'b0;
  endtask

  logic [27:0] ev1 [10];
  logic        stable;

  initial begin
    ev1 = '{28'd600, 28'd650, 28'd700, 28'd800, 28'd850, 28'd900, 28'd880, 28'd800, 28'd750, 28'd700};
    RESET_N = 1'b0; START = 1'b0; STOP = 1'b0; SAMPLE_VALID = 1'b1;
    ADDER_TRIGGER = 1'b0; ADDER_CUSUM = '0; EVT_READY = 1'b0;
    #22;
    chk_vec("rst_busy", 32'(BUSY), 32'd0);
    chk_vec("rst_enable", 32'(ADDER_ENABLE), 32'd0);
    chk_vec("rst_clear", 32'(ADDER_CLEAR), 32'd0);
    chk_vec("rst_valid", 32'(EVT_VALID), 32'd0);
    chk_vec("rst_evtcnt", EVT_COUNT, 32'd0);
    chk_vec("rst_rejcnt", 32'(REJ_COUNT), 32'd0);
    SAMPLE_VALID = 1'b0;
    RESET_N = 1'b1;
    tick(); tick();

    // Arm, clear pulse, flush with triggers that must be ignored.
    START = 1'b1; STOP = 1'b0;
    tick();
    START = 1'b0;
    chk_vec("clear_on", 32'(ADDER_CLEAR), 32'd1);
    chk_vec("st_clear", 32'(dut.state), 32'(CLEAR));
    chk_vec("busy_on", 32'(BUSY), 32'd1);
    tick();
    chk_vec("clear_off", 32'(ADDER_CLEAR), 32'd0);
    chk_vec("st_flush", 32'(dut.state), 32'(FLUSH));
    SAMPLE_VALID = 1'b1;
    #1;
    chk_vec("enable_follows", 32'(ADDER_ENABLE), 32'd1);
    SAMPLE_VALID = 1'b0;
    for (int i = 0; i < 511; i++) sample((i % 7) == 3, 28'd5000);
    chk_vec("st_flush_511", 32'(dut.state), 32'(FLUSH));
    sample(1'b0, 28'd0);
    chk_vec("st_armed", 32'(dut.state), 32'(ARMED));

    // Normal pulse of 10 samples.
    for (int i = 0; i < 10; i++) sample(1'b1, ev1[i]);
    chk_vec("st_event", 32'(dut.state), 32'(EVENT));
    sample(1'b0, 28'd0);
    chk_vec("ev1_valid", 32'(EVT_VALID), 32'd1);
    chk_vec("ev1_width", 32'(EVT_WIDTH), 32'd10);
    chk_vec("ev1_peak", 32'(EVT_PEAK), 32'd900);
    chk_vec("ev1_sat", 32'(EVT_SAT), 32'd0);
    EVT_READY = 1'b1;
    tick();
    EVT_READY = 1'b0;
    chk_vec("ev1_count", EVT_COUNT, 32'd1);
    chk_vec("ev1_vld_drop", 32'(EVT_VALID), 32'd0);
    chk_vec("st_holdoff1", 32'(dut.state), 32'(HOLDOFF));
    for (int i = 0; i < 64; i++) sample(1'b0, 28'd0);
    chk_vec("st_armed2", 32'(dut.state), 32'(ARMED));

    // Short pulse is rejected, then dead time.
    for (int i = 0; i < 3; i++) sample(1'b1, 28'd100);
    sample(1'b0, 28'd0);
    chk_vec("rej_valid", 32'(EVT_VALID), 32'd0);
    chk_vec("rej_count", 32'(REJ_COUNT), 32'd1);
    chk_vec("st_holdoff2", 32'(dut.state), 32'(HOLDOFF));
    for (int i = 0; i < 63; i++) sample(1'b0, 28'd0);
    chk_vec("holdoff_63", 32'(dut.state), 32'(HOLDOFF));
    sample(1'b1, 28'd0);
    chk_vec("holdoff_trig", 32'(dut.state), 32'(HOLDOFF));
    sample(1'b0, 28'd0);
    chk_vec("st_armed3", 32'(dut.state), 32'(ARMED));

    // Backpressure with STOP during the wait.
    sample(1'b1, 28'd200); sample(1'b1, 28'd300); sample(1'b1, 28'd250);
    sample(1'b1, 28'd260); sample(1'b1, 28'd210); sample(1'b0, 28'd0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SAMPLE_VALID = i[0]; ADDER_TRIGGER = 1'b1; ADDER_CUSUM = 28'd999;
      STOP = (i == 5);
      tick();
      if (EVT_VALID !== 1'b1 || EVT_WIDTH !== 12'd5 || EVT_PEAK !== 28'd300) stable = 1'b0;
    end
    SAMPLE_VALID = 1'b0; ADDER_TRIGGER = 1'b0; STOP = 1'b0;
    chk_vec("bp_stable", 32'(stable), 32'd1);
    chk_vec("bp_count_hold", EVT_COUNT, 32'd1);
    chk_vec("bp_st_report", 32'(dut.state), 32'(REPORT));
    EVT_READY = 1'b1;
    tick();
    EVT_READY = 1'b0;
    chk_vec("bp_count", EVT_COUNT, 32'd2);
    chk_vec("bp_idle", 32'(dut.state), 32'(IDLE));
    chk_vec("bp_busy", 32'(BUSY), 32'd0);

    // Saturating pulse.
    START = 1'b1; tick(); START = 1'b0; tick();
    for (int i = 0; i < 512; i++) sample(1'b0, 28'd0);
    chk_vec("sat_armed", 32'(dut.state), 32'(ARMED));
    for (int i = 0; i < 4095; i++) sample(1'b1, 28'(i + 1));
    chk_vec("sat_valid", 32'(EVT_VALID), 32'd1);
    chk_vec("sat_flag", 32'(EVT_SAT), 32'd1);
    chk_vec("sat_width", 32'(EVT_WIDTH), 32'd4095);
    chk_vec("sat_peak", 32'(EVT_PEAK), 32'd4095);
    EVT_READY = 1'b1; tick(); EVT_READY = 1'b0;
    chk_vec("sat_count", EVT_COUNT, 32'd3);

    // Asynchronous reset in the middle of a pulse.
    for (int i = 0; i < 64; i++) sample(1'b0, 28'd0);
    for (int i = 0; i < 3; i++) sample(1'b1, 28'd77);
    chk_vec("pre_rst_event", 32'(dut.state), 32'(EVENT));
    RESET_N = 1'b0;
    #2;
    chk_vec("arst_idle", 32'(dut.state), 32'(IDLE));
    chk_vec("arst_busy", 32'(BUSY), 32'd0);
    chk_vec("arst_count", EVT_COUNT, 32'd0);
    chk_vec("arst_rej", 32'(REJ_COUNT), 32'd0);
    chk_vec("arst_width", 32'(EVT_WIDTH), 32'd0);
    chk_vec("arst_peak", 32'(EVT_PEAK), 32'd0);
    chk_vec("arst_valid", 32'(EVT_VALID), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_sequencer.md
EVENT_SEQUENCER -- requirements
Module: event_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 14, meaning ADC sample width.
REQ-002 SHALL have parameter SWIDTH, default 28 (2*DWIDTH), meaning running-sum width.
REQ-003 SHALL have parameter MAX_SAMPLES, default 512, meaning adder window length in samples.
REQ-004 SHALL have parameters MIN_WIDTH (default 4), MAX_WIDTH (default 4095) and DEAD_TIME (default 64), all counted in enabled samples.
REQ-005 SHALL have port CLOCK, input, 1, sole clock; one clock domain; RESET_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have START (in, 1), a one-cycle arm pulse, and STOP (in, 1), a one-cycle disarm pulse.
REQ-007 SHALL have SAMPLE_VALID (in, 1), the ADC new-sample strobe.
REQ-008 SHALL have ADDER_TRIGGER (in, 1) and ADDER_CUSUM (in, SWIDTH), both driven from the cumulative adder.
REQ-009 SHALL have ADDER_ENABLE (out, 1) and ADDER_CLEAR (out, 1), both driving the cumulative adder.
REQ-010 SHALL have EVT_VALID (out, 1) and EVT_READY (in, 1), the event-record handshake.
REQ-011 SHALL have EVT_PEAK (out, SWIDTH), EVT_WIDTH (out, 12) and EVT_SAT (out, 1), forming the event record.
REQ-012 SHALL have EVT_COUNT (out, 32), REJ_COUNT (out, 16) and BUSY (out, 1).

Function
REQ-013 SHALL implement the states IDLE, CLEAR, FLUSH, ARMED, EVENT, REPORT and HOLDOFF.
REQ-014 SHALL drive ADDER_ENABLE = SAMPLE_VALID in every state except IDLE and CLEAR, where it SHALL be 0.
REQ-015 SHALL sample ADDER_TRIGGER/ADDER_CUSUM only on cycles where ADDER_ENABLE was 1 on the previous cycle ("qualified cycle"), compensating for the adder's one-cycle output latency.
REQ-016 SHALL go from IDLE to CLEAR on START; CLEAR SHALL assert ADDER_CLEAR for exactly 1 cycle and then go to FLUSH.
REQ-017 SHALL stay in FLUSH for MAX_SAMPLES qualified cycles (window refill) and then go to ARMED; triggers seen in FLUSH SHALL be ignored.
REQ-018 SHALL go from ARMED to EVENT on a qualified cycle with ADDER_TRIGGER=1, loading width=1 and peak=ADDER_CUSUM.
REQ-019 SHALL, in EVENT on each qualified cycle with ADDER_TRIGGER=1, increment width and set peak=max(peak, ADDER_CUSUM) as an unsigned compare.
REQ-020 SHALL, in EVENT on a qualified cycle with ADDER_TRIGGER=0, go to REPORT if width>=MIN_WIDTH, else increment REJ_COUNT and go to HOLDOFF.
REQ-021 SHALL, when width reaches MAX_WIDTH, saturate width, set EVT_SAT=1 and go to REPORT immediately.
REQ-022 SHALL, in REPORT, hold EVT_VALID=1 with a stable record until EVT_VALID&EVT_READY; on that cycle it SHALL increment EVT_COUNT, drop EVT_VALID and go to HOLDOFF.
REQ-023 SHALL keep the adder running in REPORT; triggers seen in REPORT SHALL be ignored.
REQ-024 SHALL stay in HOLDOFF for DEAD_TIME qualified cycles and then go to ARMED only once a qualified ADDER_TRIGGER=0 is seen.
REQ-025 SHALL go to IDLE on STOP from any state next cycle, except REPORT, where STOP is latched and honoured after the handshake.
REQ-026 SHALL let STOP win over START when both occur in the same cycle, and SHALL ignore START outside IDLE.
REQ-027 SHALL wrap EVT_COUNT modulo 2^32 and saturate REJ_COUNT at 16'hFFFF.
REQ-028 SHALL drive BUSY=1 in every state except IDLE.

Reset
REQ-029 SHALL, on RESET_N=0, asynchronously enter IDLE and clear all outputs, counters and the record to 0, including EVT_VALID=0 and ADDER_CLEAR=0.
REQ-030 SHALL abandon any pending record when reset occurs mid-REPORT, without incrementing EVT_COUNT.

Configuration
REQ-031 SHALL, with EVENT_TIMESTAMP_EN defined, add output EVT_TIME (32), a free-running qualified-cycle counter captured at EVENT entry; without the macro the port and counter SHALL be absent.

Structure
REQ-032 SHALL put the state enum, the EVT_WIDTH/counter widths and the default parameters in the shared package citometer_pkg.
REQ-033 SHALL implement the peak/width capture in one sub-module, event_capture; the FSM and counters SHALL live in the top.

Verification
REQ-034 SHALL cover: START, then 512 SAMPLE_VALID -> ADDER_CLEAR 1 cycle, ARMED after 512th qualified sample, triggers ignored during FLUSH.
REQ-035 SHALL cover: trigger high for 10 qualified cycles with CUSUM 600..900..700 -> EVT_WIDTH=10, EVT_PEAK=900, EVT_SAT=0, EVT_COUNT=1.
REQ-036 SHALL cover: trigger high for 3 cycles -> no EVT_VALID, REJ_COUNT=1, HOLDOFF 64 samples.
REQ-037 SHALL cover: EVT_READY low for 20 cycles -> record stable, then a single EVT_COUNT increment; STOP during the wait -> IDLE after the handshake.
REQ-038 SHALL cover: trigger held for 4095 samples -> EVT_SAT=1, EVT_WIDTH=4095.
REQ-039 SHALL cover: RESET_N low mid-EVENT -> IDLE, all outputs 0 asynchronously.
